// File: rtl/xbus_arbiter.sv
// Two-master arbiter and transaction sequencer for the shared decoded data bus.
// Round-robin on contention; each access ends by slave ready, decoder trap or timeout.
module xbus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    input  logic              bus_trap,
    output logic              grant
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r;
    logic              rr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              grant_r;
    logic              bus_sel_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic              bus_we_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic              m0_ack_r, m0_err_r, m1_ack_r, m1_err_r;
    logic [DATA_W-1:0] m0_rdata_r, m1_rdata_r;

    logic              any_req_s;
    logic              pick_s;
    logic [ADDR_W-1:0] pick_addr_s;
    logic              pick_we_s;
    logic [DATA_W-1:0] pick_wdata_s;
    logic              done_s;
    logic              err_s;
    logic [DATA_W-1:0] rdata_s;

    // Arbitration: a lone requester wins, a tie goes to the round-robin pointer.
    always_comb begin
        any_req_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
            pick_s = rr_r;
        end else if (m1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        if (pick_s) begin
            pick_addr_s  = m1_addr;
            pick_we_s    = m1_we;
            pick_wdata_s = m1_wdata;
        end else begin
            pick_addr_s  = m0_addr;
            pick_we_s    = m0_we;
            pick_wdata_s = m0_wdata;
        end
    end

    // Completion decode: trap beats ready, and anything without ready is an error.
    always_comb begin
        done_s = bus_trap | bus_ready | (cnt_r == CNT_LAST);
        err_s  = bus_trap | ~bus_ready;
        if (err_s || bus_we_r) begin
            rdata_s = {DATA_W{1'b0}};
        end else begin
            rdata_s = bus_rdata;
        end
    end

    // Sequencer FSM with all bus and master outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            rr_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            grant_r     <= 1'b0;
            bus_sel_r   <= 1'b0;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_we_r    <= 1'b0;
            bus_wdata_r <= {DATA_W{1'b0}};
            m0_ack_r    <= 1'b0;
            m0_err_r    <= 1'b0;
            m0_rdata_r  <= {DATA_W{1'b0}};
            m1_ack_r    <= 1'b0;
            m1_err_r    <= 1'b0;
            m1_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r     <= pick_s;
                        bus_sel_r   <= 1'b1;
                        bus_addr_r  <= pick_addr_s;
                        bus_we_r    <= pick_we_s;
                        bus_wdata_r <= pick_wdata_s;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (done_s) begin
                        bus_sel_r <= 1'b0;
                        state_r   <= ST_DONE;
                        if (grant_r) begin
                            m1_ack_r   <= 1'b1;
                            m1_err_r   <= err_s;
                            m1_rdata_r <= rdata_s;
                        end else begin
                            m0_ack_r   <= 1'b1;
                            m0_err_r   <= err_s;
                            m0_rdata_r <= rdata_s;
                        end
                    end
                end
                ST_DONE: begin
                    m0_ack_r   <= 1'b0;
                    m0_err_r   <= 1'b0;
                    m0_rdata_r <= {DATA_W{1'b0}};
                    m1_ack_r   <= 1'b0;
                    m1_err_r   <= 1'b0;
                    m1_rdata_r <= {DATA_W{1'b0}};
                    rr_r       <= ~grant_r;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    bus_sel_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign bus_sel   = bus_sel_r;
    assign bus_addr  = bus_addr_r;
    assign bus_we    = bus_we_r;
    assign bus_wdata = bus_wdata_r;
    assign m0_ack    = m0_ack_r;
    assign m0_err    = m0_err_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_ack    = m1_ack_r;
    assign m1_err    = m1_err_r;
    assign m1_rdata  = m1_rdata_r;

endmodule

// File: doc/xbus_arbiter.md
# xbus_arbiter

- Two-requester arbiter and transaction sequencer in front of the picoVersat address decoder.
- Shares the single decoded data bus between the CPU master (m0) and a secondary master (m1, DMA or host debug port).
- Registers each granted request, holds the bus until the slave signals ready, returns read data with a one-cycle acknowledge, and aborts accesses that trap or time out.

## Interface
Parameters:
- ADDR_W, `ADDR_W (xdefs.vh): address width.
- DATA_W, 32: data width.
- TIMEOUT, 256: maximum ACCESS cycles before abort; legal range 2..65535.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- m0_req  in  1  CPU request; held high until m0_ack.
- m0_addr  in  ADDR_W  CPU address.
- m0_we  in  1  CPU write enable.
- m0_wdata  in  DATA_W  CPU write data.
- m0_rdata  out  DATA_W  CPU read data; valid while m0_ack is high.
- m0_ack  out  1  CPU one-cycle completion pulse.
- m0_err  out  1  CPU error flag; qualifies m0_ack.
- m1_req, m1_addr, m1_we, m1_wdata, m1_rdata, m1_ack, m1_err: same as m0_*, for the secondary master.
- bus_sel  out  1  global select to the decoder.
- bus_addr  out  ADDR_W  registered address to the decoder.
- bus_we  out  1  registered write enable.
- bus_wdata  out  DATA_W  registered write data.
- bus_rdata  in  DATA_W  decoder read mux output (data_to_rd).
- bus_ready  in  1  slave completion; sampled only while bus_sel = 1.
- bus_trap  in  1  decoder trap_sel; unmapped address.
- grant  out  1  index of the current or last granted master.

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: bus driven, waiting for completion.
  - DONE: ack cycle.
- IDLE:
  - If no req, stay in IDLE.
  - If only one master requests, grant it.
  - If both request, grant master rr (round-robin pointer).
  - On grant: latch addr/we/wdata into bus_* registers, set grant, clear timeout counter, go to ACCESS.
- ACCESS:
  - bus_sel = 1; the counter increments every cycle.
  - Checked in priority order:
    1. bus_trap = 1: err = 1, rdata = 0, go to DONE.
    2. bus_ready = 1: capture bus_rdata into the granted master's rdata, err = 0, go to DONE.
    3. Counter = TIMEOUT-1: err = 1, rdata = 0, go to DONE.
- DONE:
  - Granted master's ack = 1 for exactly this cycle, with its err.
  - rr <= ~grant. Go to IDLE.
- Non-granted master: ack, err and rdata stay 0 throughout.
- Writes also complete via ready/trap/timeout; rdata = 0 on write.
- A req that drops while its transaction is in flight is ignored; the transaction completes and is acked anyway.
- Width rules:
  - Counter width is clog2(TIMEOUT).
  - Counter saturates and never wraps.
  - bus_addr is passed through with no offset arithmetic.

## Timing
- Reset values (asserted asynchronously):
  - state = IDLE.
  - bus_sel, bus_we, bus_addr, bus_wdata = 0.
  - m*_ack, m*_err, m*_rdata = 0.
  - grant = 0, rr = 0 (m0 wins the first tie), counter = 0.
- Reset mid-ACCESS: bus_sel drops immediately and no ack is issued for the aborted transfer.
- bus_sel, bus_addr, bus_we and bus_wdata are registered outputs and stable for the whole ACCESS phase.
- Latency, with req first sampled high at edge k:
  - ACCESS starts at k+1.
  - If ready in the first ACCESS cycle, DONE (ack high) is cycle k+2.
  - Minimum request-to-ack latency is 2 cycles.
  - Every further wait cycle adds 1.
- Timeout: ack arrives exactly TIMEOUT cycles after entering ACCESS, plus the DONE cycle.
- Back-to-back: IDLE follows DONE. A master sampling ack may present a new request in that IDLE cycle, giving a 3-cycle issue interval per master.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, ...
- Simultaneous trap and ready: trap wins (err = 1).

## Test plan
- Single read: m0_req with addr 0x10; bus_ready high in the first ACCESS cycle with bus_rdata = 0xCAFE0001 -> m0_ack for 1 cycle, exactly 2 cycles after the request edge, m0_rdata = 0xCAFE0001, m0_err = 0, m1_ack stays 0.
- Contention: m0_req and m1_req held high together for 4 transactions, ready immediate -> grant sequence 0, 1, 0, 1; each ack pulses once; bus_addr matches the granted master.
- Wait states: m1 write with wdata 0x55, bus_ready delayed 5 cycles -> bus_sel high for 6 cycles with bus_we = 1 and bus_wdata = 0x55 constant; m1_ack follows, with m1_err = 0.
- Trap and timeout:
  - bus_trap in the first ACCESS cycle -> err ack at request+2, rdata = 0.
  - With TIMEOUT = 8 and no ready -> bus_sel high for exactly 8 cycles, then m0_ack with m0_err = 1.
  - Trap and ready together -> err = 1.
- Reset mid-ACCESS: rst driven low during the 3rd wait cycle -> bus_sel goes 0 asynchronously and all outputs are 0. After release, a pending m1 request is served with no spurious m0_ack.
